uart_tx_queue: RTL and testbench

Byte queue and launch controller that sits directly upstream of the `uart_tx` serializer. It accepts bytes from any on-chip producer (switch sampler, command responder) at up to one per clock, buffers them in a FIFO, and hands them to `uart_tx` one frame at a time using that core's `i_Tx_DV` / `o_Tx_Active` / `o_Tx_Done` handshake. Producers therefore never need to track serializer state, and back-to-back writes are not lost while a frame is in flight.

---
 rtl/uart_tx_queue.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte FIFO and launch controller in front of the uart_tx serializer.
// Producers write bytes at up to one per clock. The controller hands them
// to uart_tx one frame at a time using the i_Tx_DV / o_Tx_Active /
// o_Tx_Done handshake, so producers never have to track serializer state.

module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    input  logic                  i_Wr_DV,
    input  logic [7:0]            i_Wr_Byte,
    input  logic                  i_Clr_Ovf,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Occupancy value that means "full": only the MSB of the counter set.
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    // Queue storage; no reset so it maps onto block RAM.
    logic [7:0]              mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
    logic [DEPTH_LOG2:0]     count_reg;
    logic [DEPTH_LOG2:0]     count_next;
    logic                    full_reg;
    logic                    empty_reg;
    logic                    overflow_reg;
    logic                    act_d_reg;
    logic [7:0]              tx_byte_reg;

    logic                    wr_accept;
    logic                    wr_drop;
    logic                    ser_busy;
    logic                    pop;

    // Fullness is judged on the registered (pre-edge) flag, so a write
    // while full is dropped even if a pop frees a slot on the same edge.
    // Writes presented during reset are ignored.
    assign wr_accept = i_Rst_L & i_Wr_DV & ~full_reg;
    assign wr_drop   = i_Rst_L & i_Wr_DV &  full_reg;

    // uart_tx drops o_Tx_Active one cycle before it can accept a new
    // byte (its cleanup cycle), so the delayed copy extends the busy window.
    assign ser_busy  = i_Tx_Active | act_d_reg;

    // The only pop point: the IDLE->SEND transition.
    assign pop       = (state_reg == ST_IDLE) & ~empty_reg & ~ser_busy;

    // Occupancy after this edge: a write and a pop together cancel out.
    always_comb begin
        count_next = count_reg;
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Queue storage write port; the array has no reset, only the pointers do.
    always_ff @(posedge i_Clock) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= i_Wr_Byte;
        end
    end

    // Registered read port: the head byte is captured into o_Tx_Byte on a pop
    // and held until the next pop.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            tx_byte_reg <= 8'h00;
        end else if (pop) begin
            tx_byte_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers wrap naturally modulo the queue depth; occupancy is tracked
    // separately so full and empty are never ambiguous.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == COUNT_FULL);
            empty_reg <= (count_next == '0);
        end
    end

    // Sticky overflow flag; a dropped write beats a clear on the same edge.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            overflow_reg <= 1'b0;
        end else if (wr_drop) begin
            overflow_reg <= 1'b1;
        end else if (i_Clr_Ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    // One-cycle delayed copy of the serializer's active flag.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            act_d_reg <= 1'b0;
        end else begin
            act_d_reg <= i_Tx_Active;
        end
    end

    // Launch FSM state register.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Launch FSM next state. Done pulses outside WAIT_DONE are ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Launch FSM outputs: the data-valid pulse is exactly the SEND cycle.
    always_comb begin
        o_Tx_DV = 1'b0;
        if (state_reg == ST_SEND) begin
            o_Tx_DV = 1'b1;
        end
    end

    assign o_Tx_Byte  = tx_byte_reg;
    assign o_Count    = count_reg;
    assign o_Full     = full_reg;
    assign o_Empty    = empty_reg;
    assign o_Overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
// Directed bench for uart_tx_queue. A behavioural uart_tx model answers each
// o_Tx_DV with a fixed-length frame (Active high, then a Done pulse). Bytes
// expected on the line are pushed into a scoreboard queue by the stimulus and
// popped by an independent monitor at every launch.

module tb_uart_tx_queue;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int FRAME = 10;

    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    logic           wr_dv = 1'b0;
    logic [7:0]     wr_byte = 8'h00;
    logic           clr_ovf = 1'b0;
    logic           full;
    logic           empty;
    logic [DL2:0]   count;
    logic           ovf;
    logic           tx_dv;
    logic [7:0]     tx_byte;

    logic           model_active = 1'b0;
    logic           force_active = 1'b0;
    logic           model_done = 1'b0;
    logic           stray_done = 1'b0;
    logic           tx_active;
    logic           tx_done;
    bit             ser_busy = 1'b0;

    assign tx_active = model_active | force_active;
    assign tx_done   = model_done | stray_done;

    int             errors = 0;
    int             checks = 0;
    logic [7:0]     exp_q[$];
    int             low_run = 0;
    bit             prev_dv = 1'b0;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH_LOG2(DL2)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_l),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .i_Clr_Ovf   (clr_ovf),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write strobe; accept says whether the byte should reach the line.
    task automatic write(input logic [7:0] b, input bit accept);
        wr_dv   = 1'b1;
        wr_byte = b;
        if (accept) exp_q.push_back(b);
        tick();
        wr_dv   = 1'b0;
    endtask

    // Returns at #1 after the edge that samples the serializer's Done pulse.
    task automatic wait_done(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 500 && !ok) begin
            @(negedge clk);
            if (tx_done === 1'b1) ok = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ser_busy || tx_active === 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({name, "_drain_in_time"}, (n < 3000), 1);
        check({name, "_empty"}, empty, 1);
        check({name, "_count"}, count, 0);
    endtask

    // Behavioural uart_tx: DV sampled at an edge starts a FRAME-cycle frame,
    // then Active falls together with a one-cycle Done pulse.
    initial begin : serializer
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                ser_busy = 1'b1;
                @(posedge clk);
                #1 model_active = 1'b1;
                repeat (FRAME) @(posedge clk);
                #1;
                model_active = 1'b0;
                model_done   = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
                ser_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every launch must carry the next expected byte,
    // last one cycle, and follow at least three low samples of Active
    // (two guard edges plus the launch cycle itself).
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (tx_active === 1'b0) low_run++;
            else low_run = 0;
            if (tx_dv === 1'b1) begin
                check("dv_one_cycle", prev_dv, 0);
                check("launch_guard", (low_run >= 3), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got byte %0h, required no launch", tx_byte);
                end else begin
                    check("tx_byte", tx_byte, exp_q.pop_front());
                end
            end
            prev_dv = (tx_dv === 1'b1);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  peak;
        int  quiet_dv;
        bit  ok;

        // Reset with a write presented; it must be ignored.
        rst_l   = 1'b0;
        wr_dv   = 1'b1;
        wr_byte = 8'hEE;
        repeat (3) tick();
        wr_dv   = 1'b0;
        rst_l   = 1'b1;
        check("rst_empty",    empty,   1);
        check("rst_full",     full,    0);
        check("rst_count",    count,   0);
        check("rst_overflow", ovf,     0);
        check("rst_tx_dv",    tx_dv,   0);
        check("rst_tx_byte",  tx_byte, 8'h00);

        // Single byte: write at k, launch visible between k+1 and k+2.
        write(8'hA5, 1'b1);
        check("sb_empty_k",  empty, 0);
        check("sb_count_k",  count, 1);
        tick();
        check("sb_dv_k1",    tx_dv, 1);
        check("sb_byte_k1",  tx_byte, 8'hA5);
        check("sb_count_k1", count, 0);
        tick();
        check("sb_dv_k2",    tx_dv, 0);

        // Burst of five while the A5 frame is in flight: no pops, peak 5.
        tick();
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            write(8'(i), 1'b1);
            if (int'(count) > peak) peak = int'(count);
        end
        check("burst_peak",      peak, 5);
        check("burst_byte_held", tx_byte, 8'hA5);
        drain("burst");
        check("burst_last_byte_held", tx_byte, 8'h05);

        // Full and overflow with the serializer held busy.
        force_active = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            write(8'h80 + 8'(i), 1'b1);
            if (i == DEPTH - 2) check("ovf_not_full_yet", full, 0);
        end
        check("ovf_full",       full,  1);
        check("ovf_count_full", count, DEPTH);
        check("ovf_flag_clear", ovf,   0);
        write(8'hF0, 1'b0);
        check("ovf_set",        ovf,   1);
        check("ovf_count_held", count, DEPTH);
        repeat (3) tick();
        check("ovf_sticky",     ovf,   1);
        clr_ovf = 1'b1;
        write(8'hF1, 1'b0);
        clr_ovf = 1'b0;
        check("ovf_set_beats_clr", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared",    ovf,   0);
        // Release at edge E; pop happens at E+2, so write on E+2 while full.
        force_active = 1'b0;
        tick();
        write(8'hF2, 1'b0);
        check("ovf_pop_write_dropped", count, DEPTH - 1);
        check("ovf_pop_write_set",     ovf,   1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared_again", ovf, 0);
        drain("ovf");

        // Simultaneous write and pop with three bytes held, 40 bytes total.
        force_active = 1'b1;
        tick();
        write(8'h00, 1'b1);
        write(8'h01, 1'b1);
        write(8'h02, 1'b1);
        check("sim_primed", count, 3);
        force_active = 1'b0;
        tick();
        write(8'h03, 1'b1);
        check("sim_count_first", count, 3);
        for (int b = 4; b < 40; b++) begin
            wait_done(ok);
            check("sim_done_seen", ok, 1);
            tick();
            write(8'(b), 1'b1);
            check("sim_count", count, 3);
        end
        drain("sim");

        // Reset while a frame is shifting with three bytes queued.
        write(8'h50, 1'b1);
        write(8'h51, 1'b0);
        write(8'h52, 1'b0);
        write(8'h53, 1'b0);
        check("mid_queued", count, 3);
        tick();
        tick();
        rst_l   = 1'b0;
        wr_dv   = 1'b1;
        wr_byte = 8'hEE;
        tick();
        rst_l   = 1'b1;
        wr_dv   = 1'b0;
        check("mid_rst_empty",   empty,     1);
        check("mid_rst_count",   count,     0);
        check("mid_rst_byte",    tx_byte,   8'h00);
        check("mid_rst_dv",      tx_dv,     0);
        check("mid_frame_alive", tx_active, 1);
        write(8'h3C, 1'b1);
        check("mid_3c_queued",   count,     1);
        drain("mid");

        // Stray Done while idle and empty: nothing may launch.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        quiet_dv = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_dv === 1'b1) quiet_dv++;
            tick();
        end
        check("stray_no_dv", quiet_dv, 0);
        check("stray_empty", empty, 1);
        write(8'h77, 1'b1);
        tick();
        check("stray_launch_dv",   tx_dv,   1);
        check("stray_launch_byte", tx_byte, 8'h77);
        drain("stray");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
